// File: rtl/vending_machine_ctrl_v2.sv
// Multi-item vending controller: accumulates 500/1000 credit, vends over a req/ack handshake, and refunds on timeout.
// Change is paid out one coin per cycle. All outputs are registered, so each one appears one cycle after the input that causes it.
module vending_machine_ctrl_v2 #(
  parameter int                          N_ITEMS      = 3,
  parameter int                          CREDIT_W     = 16,
  parameter logic [N_ITEMS*CREDIT_W-1:0] PRICES       = {16'd1500, 16'd1000, 16'd500},
  parameter int                          MAX_CREDIT   = 5000,
  parameter int                          VEND_TIMEOUT = 255,
  parameter bit                          AUTO_CHANGE  = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin_500,
  input  logic                bill_1000,
  input  logic [N_ITEMS-1:0]  item_sel,
  input  logic                change_req,
  input  logic                vend_ack,
  output logic                vend_req,
  output logic [N_ITEMS-1:0]  vend_item,
  output logic                coin_reject,
  output logic                insufficient,
  output logic                vend_fault,
  output logic                change_1000,
  output logic                change_500,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  localparam int TMR_W = (VEND_TIMEOUT > 1) ? $clog2(VEND_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0]    TMR_LAST = TMR_W'(VEND_TIMEOUT - 1);
  localparam logic [CREDIT_W:0]   MAX_C    = (CREDIT_W + 1)'(MAX_CREDIT);
  localparam logic [CREDIT_W-1:0] C500     = CREDIT_W'(500);
  localparam logic [CREDIT_W-1:0] C1000    = CREDIT_W'(1000);

  typedef enum logic [1:0] {S_IDLE, S_VEND, S_CHANGE} state_t;

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] price_q, price_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [N_ITEMS-1:0]  item_q, item_d;
  logic                vend_req_q, vend_req_d;
  logic                coin_reject_q, coin_reject_d;
  logic                insufficient_q, insufficient_d;
  logic                vend_fault_q, vend_fault_d;
  logic                change_1000_q, change_1000_d;
  logic                change_500_q, change_500_d;

  logic                coin_any;
  logic [CREDIT_W:0]   credit_sum;
  logic [N_ITEMS-1:0]  sel_onehot;
  logic [CREDIT_W-1:0] sel_price;

  // Two's-complement trick isolates the lowest set bit, so the lowest index wins.
  always_comb begin
    sel_onehot = item_sel & (~item_sel + N_ITEMS'(1));
    sel_price  = '0;
    for (int i = 0; i < N_ITEMS; i++) begin
      if (sel_onehot[i]) sel_price = PRICES[i*CREDIT_W +: CREDIT_W];
    end
  end

  assign coin_any   = coin_500 | bill_1000;
  assign credit_sum = {1'b0, credit_q} + {1'b0, (bill_1000 ? C1000 : C500)};

  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    price_d        = price_q;
    timer_d        = timer_q;
    item_d         = item_q;
    vend_req_d     = vend_req_q;
    coin_reject_d  = 1'b0;
    insufficient_d = 1'b0;
    vend_fault_d   = 1'b0;
    change_1000_d  = 1'b0;
    change_500_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (coin_500 && bill_1000) begin
          coin_reject_d = 1'b1;
        end else if (coin_any) begin
          if (credit_sum <= MAX_C) credit_d = credit_sum[CREDIT_W-1:0];
          else coin_reject_d = 1'b1;
        end else if (|item_sel) begin
          if (credit_q >= sel_price) begin
            credit_d   = credit_q - sel_price;
            price_d    = sel_price;
            item_d     = sel_onehot;
            vend_req_d = 1'b1;
            timer_d    = '0;
            state_d    = S_VEND;
          end else begin
            insufficient_d = 1'b1;
          end
        end else if (change_req && credit_q != '0) begin
          state_d = S_CHANGE;
        end
      end
      S_VEND: begin
        coin_reject_d = coin_any;
        // An ack that lands on the timeout cycle still counts as a good vend.
        if (vend_ack) begin
          vend_req_d = 1'b0;
          item_d     = '0;
          state_d    = (AUTO_CHANGE && credit_q != '0) ? S_CHANGE : S_IDLE;
        end else if (timer_q == TMR_LAST) begin
          credit_d     = credit_q + price_q;
          vend_fault_d = 1'b1;
          vend_req_d   = 1'b0;
          item_d       = '0;
          state_d      = S_CHANGE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_CHANGE: begin
        coin_reject_d = coin_any;
        if (credit_q >= C1000) begin
          change_1000_d = 1'b1;
          credit_d      = credit_q - C1000;
        end else if (credit_q == C500) begin
          change_500_d = 1'b1;
          credit_d     = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      credit_q       <= '0;
      price_q        <= '0;
      timer_q        <= '0;
      item_q         <= '0;
      vend_req_q     <= 1'b0;
      coin_reject_q  <= 1'b0;
      insufficient_q <= 1'b0;
      vend_fault_q   <= 1'b0;
      change_1000_q  <= 1'b0;
      change_500_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      price_q        <= price_d;
      timer_q        <= timer_d;
      item_q         <= item_d;
      vend_req_q     <= vend_req_d;
      coin_reject_q  <= coin_reject_d;
      insufficient_q <= insufficient_d;
      vend_fault_q   <= vend_fault_d;
      change_1000_q  <= change_1000_d;
      change_500_q   <= change_500_d;
    end
  end

  assign vend_req     = vend_req_q;
  assign vend_item    = item_q;
  assign coin_reject  = coin_reject_q;
  assign insufficient = insufficient_q;
  assign vend_fault   = vend_fault_q;
  assign change_1000  = change_1000_q;
  assign change_500   = change_500_q;
  assign credit       = credit_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_vending_machine_ctrl_v2.sv
// Scoreboarded bench: the driver pushes the modelled next-cycle outputs, and the monitor compares them one cycle later.
module tb_vending_machine_ctrl_v2;
  localparam int N    = 3;
  localparam int W    = 16;
  localparam int MAXC = 5000;
  localparam int TMO  = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1, coin_500 = 1'b0, bill_1000 = 1'b0, change_req = 1'b0, vend_ack = 1'b0;
  logic [N-1:0] item_sel = '0;
  logic         vend_req, coin_reject, insufficient, vend_fault, change_1000, change_500, busy;
  logic [N-1:0] vend_item;
  logic [W-1:0] credit;

  always #5 clk = ~clk;

  vending_machine_ctrl_v2 #(.N_ITEMS(N), .CREDIT_W(W), .MAX_CREDIT(MAXC), .VEND_TIMEOUT(TMO), .AUTO_CHANGE(1'b1)) dut (
    .clk(clk), .reset(reset), .coin_500(coin_500), .bill_1000(bill_1000), .item_sel(item_sel),
    .change_req(change_req), .vend_ack(vend_ack), .vend_req(vend_req), .vend_item(vend_item),
    .coin_reject(coin_reject), .insufficient(insufficient), .vend_fault(vend_fault),
    .change_1000(change_1000), .change_500(change_500), .credit(credit), .busy(busy)
  );

  typedef struct packed {
    logic         vend_req;
    logic [N-1:0] vend_item;
    logic         coin_reject;
    logic         insufficient;
    logic         vend_fault;
    logic         change_1000;
    logic         change_500;
    logic [W-1:0] credit;
    logic         busy;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: mode 0 = idle, 1 = waiting on dispenser, 2 = paying change.
  int m_mode = 0, m_credit = 0, m_item = 0, m_wait = 0;
  int price_tbl[N] = '{500, 1000, 1500};

  task automatic model_step(input bit rst, input bit c5, input bit b10, input logic [N-1:0] sel,
                            input bit chg, input bit ack, output obs_t e);
    int idx;
    e = '0;
    if (rst) begin
      m_mode = 0; m_credit = 0; m_item = 0; m_wait = 0;
    end else if (m_mode == 0) begin
      if (c5 && b10) e.coin_reject = 1'b1;
      else if (c5 || b10) begin
        if (m_credit + (c5 ? 500 : 1000) <= MAXC) m_credit += (c5 ? 500 : 1000);
        else e.coin_reject = 1'b1;
      end else if (sel != 0) begin
        idx = 0;
        while (!sel[idx]) idx++;
        if (m_credit >= price_tbl[idx]) begin
          m_credit -= price_tbl[idx]; m_item = idx; m_wait = 0; m_mode = 1;
        end else e.insufficient = 1'b1;
      end else if (chg && m_credit > 0) m_mode = 2;
    end else if (m_mode == 1) begin
      e.coin_reject = c5 || b10;
      if (ack) m_mode = (m_credit > 0) ? 2 : 0;
      else begin
        m_wait++;
        if (m_wait == TMO) begin
          m_credit += price_tbl[m_item]; e.vend_fault = 1'b1; m_mode = 2;
        end
      end
    end else begin
      e.coin_reject = c5 || b10;
      if (m_credit >= 1000) begin e.change_1000 = 1'b1; m_credit -= 1000; end
      else if (m_credit == 500) begin e.change_500 = 1'b1; m_credit = 0; end
      else m_mode = 0;
    end
    e.vend_req  = (m_mode == 1);
    e.vend_item = (m_mode == 1) ? N'(1 << m_item) : '0;
    e.credit    = W'(m_credit);
    e.busy      = (m_mode != 0);
  endtask

  task automatic cycle(input bit rst, input bit c5, input bit b10, input logic [N-1:0] sel,
                       input bit chg, input bit ack);
    obs_t e;
    @(negedge clk);
    reset = rst; coin_500 = c5; bill_1000 = b10; item_sel = sel; change_req = chg; vend_ack = ack;
    model_step(rst, c5, b10, sel, chg, ack, e);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(0, 0, 0, '0, 0, 0);
  endtask

  task automatic expect_now(input string name, input int exp_credit, input bit exp_busy);
    @(posedge clk); #2;
    checks++;
    if (credit !== W'(exp_credit) || busy !== exp_busy) begin
      failures++;
      $display("FAIL %s: credit=%0d busy=%b, expected credit=%0d busy=%b", name, credit, busy, exp_credit, exp_busy);
    end
  endtask

  obs_t mon_exp, mon_act;
  initial begin
    forever begin
      @(posedge clk); #1;
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        mon_act = {vend_req, vend_item, coin_reject, insufficient, vend_fault, change_1000, change_500, credit, busy};
        checks++;
        if (mon_act !== mon_exp) begin
          failures++;
          $display("FAIL outputs t=%0t got req=%b item=%b rej=%b ins=%b flt=%b c1k=%b c500=%b cr=%0d busy=%b want req=%b item=%b rej=%b ins=%b flt=%b c1k=%b c500=%b cr=%0d busy=%b",
                   $time, mon_act.vend_req, mon_act.vend_item, mon_act.coin_reject, mon_act.insufficient,
                   mon_act.vend_fault, mon_act.change_1000, mon_act.change_500, mon_act.credit, mon_act.busy,
                   mon_exp.vend_req, mon_exp.vend_item, mon_exp.coin_reject, mon_exp.insufficient,
                   mon_exp.vend_fault, mon_exp.change_1000, mon_exp.change_500, mon_exp.credit, mon_exp.busy);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] rsel;
    cycle(1, 0, 0, '0, 0, 0);
    cycle(1, 0, 0, '0, 0, 0); expect_now("reset", 0, 0);
    // Vend of the 1500 item with a late ack.
    cycle(0, 0, 1, '0, 0, 0); expect_now("bill_to_1000", 1000, 0);
    cycle(0, 1, 0, '0, 0, 0); expect_now("coin_to_1500", 1500, 0);
    cycle(0, 0, 0, 3'b100, 0, 0); expect_now("vend_start", 0, 1);
    idle(2);
    cycle(0, 0, 0, '0, 0, 1); expect_now("ack_to_idle", 0, 0);
    // Auto change after a 500 vend from 3000.
    cycle(0, 0, 1, '0, 0, 0); cycle(0, 0, 1, '0, 0, 0); cycle(0, 0, 1, '0, 0, 0);
    cycle(0, 0, 0, 3'b001, 0, 0); expect_now("vend_item0", 2500, 1);
    cycle(0, 0, 0, '0, 0, 1);
    idle(3);
    cycle(0, 0, 0, '0, 0, 0); expect_now("change_done", 0, 0);
    // Ceiling handling.
    for (int k = 0; k < 4; k++) cycle(0, 0, 1, '0, 0, 0);
    cycle(0, 1, 0, '0, 0, 0);
    cycle(0, 0, 1, '0, 0, 0); expect_now("over_ceiling", 4500, 0);
    cycle(0, 1, 0, '0, 0, 0); expect_now("at_ceiling", 5000, 0);
    cycle(0, 1, 1, '0, 0, 0); expect_now("both_coins", 5000, 0);
    cycle(0, 0, 0, '0, 1, 0);
    idle(7);
    // Insufficient credit, then coin beats selection.
    cycle(0, 1, 0, '0, 0, 0);
    cycle(0, 0, 0, 3'b010, 0, 0); expect_now("insufficient", 500, 0);
    cycle(0, 1, 0, 3'b010, 0, 0); expect_now("coin_priority", 1000, 0);
    // Dispenser timeout refund.
    cycle(0, 0, 1, '0, 0, 0);
    cycle(0, 0, 0, 3'b100, 0, 0);
    idle(3);
    cycle(0, 0, 0, '0, 0, 0); expect_now("timeout_refund", 2000, 1);
    cycle(0, 0, 0, '0, 0, 0); expect_now("first_change", 1000, 1);
    idle(3);
    // Reset during change.
    cycle(0, 0, 1, '0, 0, 0); cycle(0, 0, 1, '0, 0, 0); cycle(0, 0, 1, '0, 0, 0);
    cycle(0, 0, 0, '0, 1, 0);
    cycle(0, 0, 0, '0, 0, 0); expect_now("change_before_reset", 2000, 1);
    cycle(1, 0, 0, '0, 0, 0); expect_now("reset_in_change", 0, 0);
    idle(3);
    // Randomised traffic.
    for (int k = 0; k < 3000; k++) begin
      rsel = ($urandom_range(0, 3) == 0) ? N'($urandom_range(1, 7)) : '0;
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 15,
            rsel, $urandom_range(0, 9) == 0, $urandom_range(0, 99) < 30);
    end
    idle(2);
    @(posedge clk); #3;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected entries left, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
